// File: rtl/rv_trace_pkg.sv
// Shared types and helpers for the RV12 retirement trace collector.
// Holds the trace record layout, the reset defaults and the record normalisation.
package rv_trace_pkg;

    localparam int REC_XLEN = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    localparam logic [REC_XLEN-1:0] PC_INIT_DEFAULT = 32'h0000_0200;

    typedef struct packed {
        logic [63:0]         order;
        logic [REC_XLEN-1:0] pc;
        logic [31:0]         insn;
        logic [4:0]          rd;
        logic [REC_XLEN-1:0] wdata;
        logic                trap;
    } trace_rec_t;

    // Traps, non-writing instructions and x0 writes all report "no register write".
    function automatic trace_rec_t make_rec(
        input logic [63:0]         order,
        input logic [REC_XLEN-1:0] pc,
        input logic [31:0]         insn,
        input logic [4:0]          rd,
        input logic                we,
        input logic [REC_XLEN-1:0] wdata,
        input logic                trap
    );
        trace_rec_t rec;
        rec.order = order;
        rec.pc    = pc;
        rec.insn  = insn;
        rec.trap  = trap;
        if (trap || !we || (rd == 5'd0)) begin
            rec.rd    = 5'd0;
            rec.wdata = {REC_XLEN{1'b0}};
        end else begin
            rec.rd    = rd;
            rec.wdata = wdata;
        end
        return rec;
    endfunction

endpackage

// File: rtl/rv_retire_trace_if.sv
// Write-back sample port and trace consumer handshake of the retirement trace collector.
// The master side is the pipeline/consumer environment, the slave side is the collector.
interface rv_retire_trace_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic            wb_valid_i;
    logic [XLEN-1:0] wb_pc_i;
    logic [31:0]     wb_insn_i;
    logic [4:0]      wb_rd_i;
    logic            wb_we_i;
    logic [XLEN-1:0] wb_wdata_i;
    logic            wb_trap_i;
    logic            clr_i;
    logic            trace_valid_o;
    logic            trace_ready_i;
    logic [63:0]     trace_order_o;
    logic [XLEN-1:0] trace_pc_o;
    logic [31:0]     trace_insn_o;
    logic [4:0]      trace_rd_o;
    logic [XLEN-1:0] trace_wdata_o;
    logic            trace_trap_o;
    logic            overflow_o;
    logic [LW-1:0]   level_o;

    modport master (
        output wb_valid_i, wb_pc_i, wb_insn_i, wb_rd_i, wb_we_i, wb_wdata_i, wb_trap_i,
        output clr_i, trace_ready_i,
        input  trace_valid_o, trace_order_o, trace_pc_o, trace_insn_o, trace_rd_o,
        input  trace_wdata_o, trace_trap_o, overflow_o, level_o
    );

    modport slave (
        input  wb_valid_i, wb_pc_i, wb_insn_i, wb_rd_i, wb_we_i, wb_wdata_i, wb_trap_i,
        input  clr_i, trace_ready_i,
        output trace_valid_o, trace_order_o, trace_pc_o, trace_insn_o, trace_rd_o,
        output trace_wdata_o, trace_trap_o, overflow_o, level_o
    );

endinterface

// File: rtl/rv_trace_fifo.sv
// Synchronous DEPTH-entry FIFO of trace records with a synchronous clear.
// A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
module rv_trace_fifo
    import rv_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  trace_rec_t               din,
    output trace_rec_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t     mem_r [DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic [AW:0]    level_r;
    logic           do_push_s;
    logic           do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];
    assign level     = level_r;

    // Record storage; no reset needed as reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !clr) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/rv_retire_trace.sv
// Retirement trace collector: normalises WB retirements, numbers them, buffers them
// and presents them to a trace consumer, flagging records lost to a full buffer.
module rv_retire_trace
    import rv_trace_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 8,
    parameter logic [XLEN-1:0] PC_INIT = PC_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    rv_retire_trace_if.slave  tr
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [63:0]   order_r;
    logic          overflow_r;
    trace_rec_t    rec_in_s;
    trace_rec_t    rec_head_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          drop_s;
    logic [LW-1:0] level_s;

    assign rec_in_s = make_rec(order_r, tr.wb_pc_i, tr.wb_insn_i, tr.wb_rd_i,
                               tr.wb_we_i, tr.wb_wdata_i, tr.wb_trap_i);
    assign pop_s    = !empty_s && tr.trace_ready_i;
    assign drop_s   = tr.wb_valid_i && full_s && !pop_s;

    rv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tr.clr_i),
        .push  (tr.wb_valid_i),
        .pop   (pop_s),
        .din   (rec_in_s),
        .dout  (rec_head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );

    // Every retirement consumes an order number, stored or dropped, so gaps expose losses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_r    <= 64'd0;
            overflow_r <= 1'b0;
        end else if (tr.clr_i) begin
            order_r    <= 64'd0;
            overflow_r <= 1'b0;
        end else begin
            if (tr.wb_valid_i) begin
                order_r <= order_r + 64'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Present the head record, or fixed idle values while the buffer is empty.
    always_comb begin
        tr.trace_valid_o = 1'b0;
        tr.trace_order_o = 64'd0;
        tr.trace_pc_o    = PC_INIT;
        tr.trace_insn_o  = RV_NOP;
        tr.trace_rd_o    = 5'd0;
        tr.trace_wdata_o = {XLEN{1'b0}};
        tr.trace_trap_o  = 1'b0;
        if (!empty_s) begin
            tr.trace_valid_o = 1'b1;
            tr.trace_order_o = rec_head_s.order;
            tr.trace_pc_o    = rec_head_s.pc;
            tr.trace_insn_o  = rec_head_s.insn;
            tr.trace_rd_o    = rec_head_s.rd;
            tr.trace_wdata_o = rec_head_s.wdata;
            tr.trace_trap_o  = rec_head_s.trap;
        end else begin
            tr.trace_valid_o = 1'b0;
        end
    end

    assign tr.overflow_o = overflow_r;
    assign tr.level_o    = level_s;

endmodule

// File: tb/tb_rv_retire_trace.sv
// Directed self-checking bench for rv_retire_trace with hand-computed expectations.
module tb_rv_retire_trace;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    rv_retire_trace_if #(.XLEN(32), .DEPTH(8)) tr ();

    rv_retire_trace #(.XLEN(32), .DEPTH(8), .PC_INIT(32'h0000_0200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tr    (tr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                          input logic we, input logic [31:0] wdata, input logic trap);
        tr.wb_valid_i = 1'b1;
        tr.wb_pc_i    = pc;
        tr.wb_insn_i  = insn;
        tr.wb_rd_i    = rd;
        tr.wb_we_i    = we;
        tr.wb_wdata_i = wdata;
        tr.wb_trap_i  = trap;
    endtask

    task automatic idle();
        tr.wb_valid_i = 1'b0;
        tr.wb_pc_i    = 32'd0;
        tr.wb_insn_i  = 32'd0;
        tr.wb_rd_i    = 5'd0;
        tr.wb_we_i    = 1'b0;
        tr.wb_wdata_i = 32'd0;
        tr.wb_trap_i  = 1'b0;
    endtask

    task automatic do_clr();
        idle();
        tr.clr_i = 1'b1;
        tick();
        tr.clr_i = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();
        tr.clr_i = 1'b0;
        tr.trace_ready_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset / empty state
        check_vec("rst_valid", 64'(tr.trace_valid_o), 64'd0);
        check_vec("rst_level", 64'(tr.level_o), 64'd0);
        check_vec("rst_ovf",   64'(tr.overflow_o), 64'd0);
        check_vec("rst_pc",    64'(tr.trace_pc_o), 64'h200);
        check_vec("rst_insn",  64'(tr.trace_insn_o), 64'h13);
        check_vec("rst_order", tr.trace_order_o, 64'd0);
        check_vec("rst_rd",    64'(tr.trace_rd_o), 64'd0);
        check_vec("rst_wdata", 64'(tr.trace_wdata_o), 64'd0);
        check_vec("rst_trap",  64'(tr.trace_trap_o), 64'd0);

        // Single retire, one-cycle latency, consumed immediately
        tr.trace_ready_i = 1'b1;
        retire(32'h200, 32'h0050_0093, 5'd1, 1'b1, 32'd5, 1'b0);
        tick();
        idle();
        check_vec("t1_valid", 64'(tr.trace_valid_o), 64'd1);
        check_vec("t1_order", tr.trace_order_o, 64'd0);
        check_vec("t1_pc",    64'(tr.trace_pc_o), 64'h200);
        check_vec("t1_insn",  64'(tr.trace_insn_o), 64'h0050_0093);
        check_vec("t1_rd",    64'(tr.trace_rd_o), 64'd1);
        check_vec("t1_wdata", 64'(tr.trace_wdata_o), 64'd5);
        tick();
        check_vec("t1_drain", 64'(tr.trace_valid_o), 64'd0);

        // Normalisation: x0 write, trap, we=0, and a plain write
        retire(32'h204, 32'h0000_0013, 5'd0, 1'b1, 32'hDEAD, 1'b0);
        tick();
        idle();
        check_vec("x0_rd",    64'(tr.trace_rd_o), 64'd0);
        check_vec("x0_wdata", 64'(tr.trace_wdata_o), 64'd0);
        check_vec("x0_order", tr.trace_order_o, 64'd1);
        tick();
        retire(32'h208, 32'h0000_0073, 5'd3, 1'b1, 32'd7, 1'b1);
        tick();
        idle();
        check_vec("trap_rd",    64'(tr.trace_rd_o), 64'd0);
        check_vec("trap_wdata", 64'(tr.trace_wdata_o), 64'd0);
        check_vec("trap_flag",  64'(tr.trace_trap_o), 64'd1);
        check_vec("trap_order", tr.trace_order_o, 64'd2);
        tick();
        retire(32'h20C, 32'h0040_0213, 5'd4, 1'b0, 32'd9, 1'b0);
        tick();
        idle();
        check_vec("nowe_rd", 64'(tr.trace_rd_o), 64'd0);
        check_vec("nowe_wdata", 64'(tr.trace_wdata_o), 64'd0);
        tick();
        retire(32'h210, 32'h1234_0293, 5'd5, 1'b1, 32'h1234, 1'b0);
        tick();
        idle();
        check_vec("wr_rd",    64'(tr.trace_rd_o), 64'd5);
        check_vec("wr_wdata", 64'(tr.trace_wdata_o), 64'h1234);
        check_vec("wr_trap",  64'(tr.trace_trap_o), 64'd0);
        check_vec("wr_order", tr.trace_order_o, 64'd4);
        tick();

        // Overflow: nine retires into an eight-entry FIFO with the consumer stalled
        do_clr();
        tr.trace_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            retire(32'h1000 + 32'(4*i), 32'h0010_0093 + 32'(i), 5'(i+1), 1'b1, 32'h100 + 32'(i), 1'b0);
            tick();
            check_vec("fill_level", 64'(tr.level_o), (i < 8) ? 64'(i+1) : 64'd8);
            check_vec("fill_ovf", 64'(tr.overflow_o), (i < 8) ? 64'd0 : 64'd1);
        end
        idle();

        // Head held stable while the consumer stalls
        for (int c = 0; c < 5; c++) begin
            tick();
            check_vec("hold_valid", 64'(tr.trace_valid_o), 64'd1);
            check_vec("hold_order", tr.trace_order_o, 64'd0);
            check_vec("hold_pc",    64'(tr.trace_pc_o), 64'h1000);
            check_vec("hold_insn",  64'(tr.trace_insn_o), 64'h0010_0093);
            check_vec("hold_rd",    64'(tr.trace_rd_o), 64'd1);
            check_vec("hold_wdata", 64'(tr.trace_wdata_o), 64'h100);
            check_vec("hold_trap",  64'(tr.trace_trap_o), 64'd0);
        end

        tr.trace_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_vec("drain_valid", 64'(tr.trace_valid_o), 64'd1);
            check_vec("drain_order", tr.trace_order_o, 64'(k));
            check_vec("drain_pc",    64'(tr.trace_pc_o), 64'h1000 + 64'(4*k));
            tick();
        end
        check_vec("drain_empty", 64'(tr.trace_valid_o), 64'd0);
        check_vec("drain_level", 64'(tr.level_o), 64'd0);
        check_vec("ovf_sticky",  64'(tr.overflow_o), 64'd1);
        retire(32'h2000, 32'h0000_0013, 5'd0, 1'b0, 32'd0, 1'b0);
        tick();
        idle();
        check_vec("post_ovf_order", tr.trace_order_o, 64'd9);
        tick();

        // Full FIFO with simultaneous push and pop
        do_clr();
        check_vec("clr_ovf", 64'(tr.overflow_o), 64'd0);
        tr.trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            retire(32'h3000 + 32'(4*i), 32'h0000_0013, 5'd2, 1'b1, 32'(i), 1'b0);
            tick();
        end
        check_vec("pp_full_level", 64'(tr.level_o), 64'd8);
        tr.trace_ready_i = 1'b1;
        retire(32'h3020, 32'h0000_0013, 5'd2, 1'b1, 32'd8, 1'b0);
        tick();
        idle();
        check_vec("pp_level", 64'(tr.level_o), 64'd8);
        check_vec("pp_ovf",   64'(tr.overflow_o), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            check_vec("pp_order", tr.trace_order_o, 64'(k));
            check_vec("pp_wdata", 64'(tr.trace_wdata_o), 64'(k));
            tick();
        end
        check_vec("pp_empty", 64'(tr.trace_valid_o), 64'd0);

        // Clear colliding with a retire at level 3
        tr.trace_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            retire(32'h4000 + 32'(4*i), 32'h0000_0013, 5'd6, 1'b1, 32'd1, 1'b0);
            tick();
        end
        check_vec("clr_pre_level", 64'(tr.level_o), 64'd3);
        retire(32'h400C, 32'h0000_0013, 5'd6, 1'b1, 32'd1, 1'b0);
        tr.clr_i = 1'b1;
        tick();
        tr.clr_i = 1'b0;
        idle();
        check_vec("clr_level", 64'(tr.level_o), 64'd0);
        check_vec("clr_valid", 64'(tr.trace_valid_o), 64'd0);
        check_vec("clr_ovf2",  64'(tr.overflow_o), 64'd0);
        tr.trace_ready_i = 1'b1;
        retire(32'h5000, 32'h0000_0013, 5'd7, 1'b1, 32'd3, 1'b0);
        tick();
        idle();
        check_vec("clr_next_order", tr.trace_order_o, 64'd0);
        check_vec("clr_next_pc", 64'(tr.trace_pc_o), 64'h5000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_retire_trace.md
# rv_retire_trace

Retirement trace collector sitting directly downstream of the RV12 write-back stage, alongside the ISA checker. Each cycle it samples the retiring instruction (PC, instruction word, destination register, write data, trap flag), normalises the record, tags it with a 64-bit retirement order number, and buffers it in a FIFO. It presents records to a trace consumer (checker, logger or formal harness) over a valid/ready handshake and flags lost records.

## Interface
- XLEN, 32, data/PC width
- DEPTH, 8, FIFO entries; power of two, ≥2
- PC_INIT, 32'h200, value of trace_pc_o while empty or in reset
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid_i  in  1  an instruction retires this cycle (WB not a bubble)
- wb_pc_i  in  XLEN  PC of retiring instruction
- wb_insn_i  in  32  instruction word
- wb_rd_i  in  5  destination register index
- wb_we_i  in  1  register-file write enable
- wb_wdata_i  in  XLEN  register write data
- wb_trap_i  in  1  instruction retired with an exception
- clr_i  in  1  synchronous clear: empties FIFO, zeroes order counter, clears overflow
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  consumer accepts head record
- trace_order_o  out  64  retirement order of head record
- trace_pc_o  out  XLEN  head PC
- trace_insn_o  out  32  head instruction
- trace_rd_o  out  5  head destination (0 = no write)
- trace_wdata_o  out  XLEN  head write data
- trace_trap_o  out  1  head trap flag
- overflow_o  out  1  sticky: at least one record dropped
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Normalisation on push: if wb_trap_i or !wb_we_i or wb_rd_i==0, store rd=0 and wdata=0; otherwise store wb_rd_i and wb_wdata_i. PC and instruction stored unmodified.
- Order counter: starts at 0; every cycle with wb_valid_i, record takes current value and counter increments by 1, whether or not the record is stored. Wraps modulo 2^64. A gap in consumed order numbers therefore identifies dropped records.
- Push: wb_valid_i and (not full or pop this cycle) → record written at tail.
- Pop: trace_valid_o and trace_ready_i → head advances.
- Full, push, no pop → record dropped, overflow_o set, FIFO contents unchanged.
- Full, push and pop same cycle → both happen; level stays DEPTH; no overflow.
- Empty, push → no fall-through; trace_valid_o rises the following cycle.
- clr_i has priority over push/pop in the same cycle; the record presented in that cycle is discarded and does not consume an order number.
- Output fields hold head contents while trace_valid_o=1 and trace_ready_i=0 (stable until accepted). While empty: order=0, pc=PC_INIT, insn=32'h13, rd=0, wdata=0, trap=0.
- Pointers wrap modulo DEPTH; full/empty resolved with an extra pointer bit.

## Timing
- Reset (async assert, sync release): trace_valid_o=0, overflow_o=0, level_o=0, order counter=0, outputs at empty values above.
- Latency: WB retire in cycle N → trace_valid_o at N+1 when FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- overflow_o rises the cycle after the dropping push; held until reset or clr_i.
- level_o reflects state after the previous edge (registered).

## Structure
- Package rv_trace_pkg: trace_rec_t struct (order, pc, insn, rd, wdata, trap), RV_NOP = 32'h13, PC_INIT default.
- Sub-module rv_trace_fifo: generic DEPTH×trace_rec_t synchronous FIFO with push/pop/clr, full/empty/level. Top contains normalisation, order counter and overflow logic.

## Test plan
- Single retire pc=0x200, insn=0x00500093 (addi x1,x0,5), rd=1, we=1, wdata=5, ready=1 → next cycle valid=1, order=0, rd=1, wdata=5; then valid=0.
- Retire rd=0 with we=1, wdata=0xDEAD → trace_rd_o=0, trace_wdata_o=0; trap retire rd=3, we=1 → rd=0, trap=1.
- ready=0, 9 consecutive retires with DEPTH=8 → level=8, overflow_o=1 from cycle after 9th; drain yields orders 0–7; next retire carries order 9.
- Full FIFO, ready=1 and retire same cycle → level stays 8, overflow_o stays 0, order numbers contiguous.
- ready held 0 for 5 cycles with valid head → all trace_* outputs unchanged across those cycles.
- clr_i asserted together with a retire while level=3 → next cycle level=0, valid=0, overflow=0; following retire reports order=0.
